// File: rtl/spi_regs_pkg.sv
// Shared types, address map and helpers for the SPI register bank.
// Address map: ID at 0x00, bad-access counter at 0x01, control at 0x10+, status at 0x20+.
package spi_regs_pkg;

  typedef logic [7:0] reg8_t;

  typedef enum logic [1:0] {
    IDLE,
    RD_HOLD,
    WR_WAIT,
    WR_DONE
  } state_t;

  localparam logic [6:0] ADDR_ID     = 7'h00;
  localparam logic [6:0] ADDR_BADCNT = 7'h01;
  localparam logic [6:0] CTRL_BASE   = 7'h10;
  localparam logic [6:0] STAT_BASE   = 7'h20;

  // Saturating increment so the illegal-access counter never wraps back to zero
  function automatic reg8_t sat_inc(input reg8_t v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/spi_reg_bank_if.sv
// Decoded-frame bus between the SPI target (master) and the register bank (slave).
// Carries header/data from the target and a tx_d/tx_en read-data handshake back.
interface spi_reg_bank_if;
  import spi_regs_pkg::*;

  logic [6:0] reg_addr;
  logic       addr_dv;
  reg8_t      rx_d;
  logic       rxdv;
  logic       rw_out;
  reg8_t      tx_d;
  logic       tx_en;

  modport master (
    output reg_addr, addr_dv, rx_d, rxdv, rw_out,
    input  tx_d, tx_en
  );

  modport slave (
    input  reg_addr, addr_dv, rx_d, rxdv, rw_out,
    output tx_d, tx_en
  );

endinterface

// File: rtl/spi_reg_rd_mux.sv
// Combinational decode of a latched register address into read data, hit flags and index.
// Zero latency; no flow control. Unmapped addresses read as 8'h00.
module spi_reg_rd_mux
  import spi_regs_pkg::*;
#(
  parameter int    NUM_RW  = 8,
  parameter int    NUM_RO  = 8,
  parameter reg8_t CHIP_ID = 8'hA5
) (
  input  logic [6:0]          addr,
  input  logic [8*NUM_RW-1:0] ctrl_regs,
  input  logic [8*NUM_RO-1:0] status_in,
  input  reg8_t               bad_cnt,
  output reg8_t               rd_data,
  output logic                hit_bad,
  output logic                hit_ctrl,
  output logic                hit_stat,
  output logic                mapped,
  output logic [3:0]          idx
);

  logic hit_id;

  assign idx      = addr[3:0];
  assign hit_id   = (addr == ADDR_ID);
  assign hit_bad  = (addr == ADDR_BADCNT);
  assign hit_ctrl = (addr[6:4] == CTRL_BASE[6:4]) && ({1'b0, idx} < 5'(NUM_RW));
  assign hit_stat = (addr[6:4] == STAT_BASE[6:4]) && ({1'b0, idx} < 5'(NUM_RO));
  assign mapped   = hit_id | hit_bad | hit_ctrl | hit_stat;

  always_comb begin
    rd_data = '0;
    if (hit_id) begin
      rd_data = CHIP_ID;
    end else if (hit_bad) begin
      rd_data = bad_cnt;
    end else if (hit_ctrl) begin
      for (int i = 0; i < NUM_RW; i++) begin
        if (idx == 4'(i)) rd_data = ctrl_regs[8*i +: 8];
      end
    end else if (hit_stat) begin
      for (int j = 0; j < NUM_RO; j++) begin
        if (idx == 4'(j)) rd_data = status_in[8*j +: 8];
      end
    end
  end

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-facing register bank: control regs, status snapshot on read, ID and saturating bad-access count.
// tx_en rises one clk after the cycle addr_rise is seen; writes land the edge data_rise is seen; no backpressure.
module spi_reg_bank
  import spi_regs_pkg::*;
#(
  parameter int    NUM_RW   = 8,
  parameter int    NUM_RO   = 8,
  parameter reg8_t CHIP_ID  = 8'hA5,
  parameter reg8_t CTRL_RST = 8'h00
) (
  input  logic                clk,
  input  logic                reset,
  spi_reg_bank_if.slave       bus,
  output logic [8*NUM_RW-1:0] ctrl_regs,
  output logic [NUM_RW-1:0]   wr_strobe,
  input  logic [8*NUM_RO-1:0] status_in,
  output logic [NUM_RO-1:0]   rd_strobe
);

  state_t     state;
  logic [6:0] addr_l;
  reg8_t      bad_cnt;
  logic       addr_dv_q;
  logic       rxdv_q;

  logic       addr_rise;
  logic       addr_fall;
  logic       data_rise;

  reg8_t      mux_data;
  logic       hit_bad;
  logic       hit_ctrl;
  logic       hit_stat;
  logic       mapped;
  logic [3:0] idx;

  assign addr_rise = bus.addr_dv & ~addr_dv_q;
  assign addr_fall = ~bus.addr_dv & addr_dv_q;
  assign data_rise = bus.rxdv & ~rxdv_q;

  spi_reg_rd_mux #(
    .NUM_RW  (NUM_RW),
    .NUM_RO  (NUM_RO),
    .CHIP_ID (CHIP_ID)
  ) u_rd_mux (
    .addr      (addr_l),
    .ctrl_regs (ctrl_regs),
    .status_in (status_in),
    .bad_cnt   (bad_cnt),
    .rd_data   (mux_data),
    .hit_bad   (hit_bad),
    .hit_ctrl  (hit_ctrl),
    .hit_stat  (hit_stat),
    .mapped    (mapped),
    .idx       (idx)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_l    <= '0;
      bad_cnt   <= '0;
      addr_dv_q <= 1'b0;
      rxdv_q    <= 1'b0;
      bus.tx_d  <= '0;
      bus.tx_en <= 1'b0;
      ctrl_regs <= {NUM_RW{CTRL_RST}};
      wr_strobe <= '0;
      rd_strobe <= '0;
    end else begin
      addr_dv_q <= bus.addr_dv;
      rxdv_q    <= bus.rxdv;
      wr_strobe <= '0;
      rd_strobe <= '0;

      case (state)
        IDLE: begin
          if (addr_rise) begin
            addr_l <= bus.reg_addr;
            state  <= bus.rw_out ? RD_HOLD : WR_WAIT;
          end
        end

        RD_HOLD: begin
          if (addr_fall) begin
            bus.tx_en <= 1'b0;
            bus.tx_d  <= '0;
            state     <= IDLE;
          end else if (!bus.tx_en) begin
            // First cycle in RD_HOLD: snapshot once, then hold until frame end
            bus.tx_d  <= mux_data;
            bus.tx_en <= 1'b1;
            if (hit_stat) begin
              for (int j = 0; j < NUM_RO; j++) begin
                if (idx == 4'(j)) rd_strobe[j] <= 1'b1;
              end
            end
            if (!mapped) bad_cnt <= sat_inc(bad_cnt);
          end
        end

        WR_WAIT: begin
          if (data_rise) begin
            if (hit_ctrl) begin
              for (int i = 0; i < NUM_RW; i++) begin
                if (idx == 4'(i)) begin
                  ctrl_regs[8*i +: 8] <= bus.rx_d;
                  wr_strobe[i]        <= 1'b1;
                end
              end
            end else if (hit_bad) begin
              bad_cnt <= '0;
            end else begin
              bad_cnt <= sat_inc(bad_cnt);
            end
            state <= addr_fall ? IDLE : WR_DONE;
          end else if (addr_fall) begin
            state <= IDLE;
          end
        end

        WR_DONE: begin
          if (addr_fall) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_reg_bank.sv
// Directed bench for spi_reg_bank: reads, writes, status snapshot, bad-access counting, aborts and reset.
// Inputs change 1 time unit after each rising edge; outputs are sampled at the same point.
module tb_spi_reg_bank;
  import spi_regs_pkg::*;

  logic        clk;
  logic        reset;
  logic [63:0] ctrl_regs;
  logic [7:0]  wr_strobe;
  logic [63:0] status_in;
  logic [7:0]  rd_strobe;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_ctrl;

  logic  rd_en0, rd_en1, rd_en2, rd_en3;
  reg8_t rd_d1, rd_d2, rd_d3;
  logic [7:0] rd_rs1, rd_rs2;

  spi_reg_bank_if bus ();

  spi_reg_bank #(
    .NUM_RW   (8),
    .NUM_RO   (8),
    .CHIP_ID  (8'hA5),
    .CTRL_RST (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ctrl_regs (ctrl_regs),
    .wr_strobe (wr_strobe),
    .status_in (status_in),
    .rd_strobe (rd_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full read frame; status_in is replaced by stat_after once tx_en has risen
  task automatic rd(input logic [6:0] a, input logic [63:0] stat_after);
    bus.reg_addr = a;
    bus.rw_out   = 1'b1;
    bus.addr_dv  = 1'b1;
    tick();
    rd_en0 = bus.tx_en;
    tick();
    rd_en1 = bus.tx_en;
    rd_d1  = bus.tx_d;
    rd_rs1 = rd_strobe;
    status_in = stat_after;
    tick();
    rd_en2 = bus.tx_en;
    rd_d2  = bus.tx_d;
    rd_rs2 = rd_strobe;
    bus.addr_dv = 1'b0;
    tick();
    rd_en3 = bus.tx_en;
    rd_d3  = bus.tx_d;
    tick();
  endtask

  // Write frame; a second rxdv pulse with 8'hEE follows to probe that WR_DONE ignores it
  task automatic wr(input logic [6:0] a, input reg8_t d,
                    output logic [7:0] strobe_hit, output logic [7:0] strobe_after,
                    output logic [63:0] ctrl_hit, output logic [63:0] ctrl_end);
    bus.reg_addr = a;
    bus.rw_out   = 1'b0;
    bus.addr_dv  = 1'b1;
    tick();
    bus.rx_d = d;
    bus.rxdv = 1'b1;
    tick();
    strobe_hit = wr_strobe;
    ctrl_hit   = ctrl_regs;
    tick();
    strobe_after = wr_strobe;
    bus.rxdv = 1'b0;
    tick();
    bus.rx_d = 8'hEE;
    bus.rxdv = 1'b1;
    tick();
    strobe_after = strobe_after | wr_strobe;
    bus.addr_dv = 1'b0;
    bus.rxdv    = 1'b0;
    tick();
    ctrl_end = ctrl_regs;
    tick();
  endtask

  initial begin
    logic [7:0]  s_hit, s_after;
    logic [63:0] c_hit, c_end;
    logic        any_strobe;

    reset        = 1'b1;
    bus.reg_addr = '0;
    bus.addr_dv  = 1'b0;
    bus.rx_d     = '0;
    bus.rxdv     = 1'b0;
    bus.rw_out   = 1'b0;
    status_in    = '0;
    exp_ctrl     = '0;
    tick();
    tick();
    check("reset_tx_en", 64'(bus.tx_en), 64'h0);
    check("reset_tx_d", 64'(bus.tx_d), 64'h0);
    check("reset_ctrl", ctrl_regs, 64'h0);
    check("reset_strobes", {48'h0, wr_strobe, rd_strobe}, 64'h0);
    reset = 1'b0;
    tick();

    rd(7'h00, status_in);
    check("id_tx_en_early", 64'(rd_en0), 64'h0);
    check("id_tx_en", 64'(rd_en1), 64'h1);
    check("id_tx_d", 64'(rd_d1), 64'hA5);
    check("id_end_tx_en", 64'(rd_en3), 64'h0);
    check("id_end_tx_d", 64'(rd_d3), 64'h0);
    rd(7'h01, status_in);
    check("badcnt_after_id", 64'(rd_d1), 64'h0);

    wr(7'h12, 8'h3C, s_hit, s_after, c_hit, c_end);
    exp_ctrl[23:16] = 8'h3C;
    check("wr12_ctrl", c_hit, exp_ctrl);
    check("wr12_strobe", 64'(s_hit), 64'h04);
    check("wr12_strobe_once", 64'(s_after), 64'h0);
    check("wr12_second_rxdv_ignored", c_end, exp_ctrl);
    rd(7'h12, status_in);
    check("rd12_tx_d", 64'(rd_d1), 64'h3C);

    status_in = 64'h0000_0000_0000_5A00;
    rd(7'h21, 64'h0);
    check("stat21_tx_d", 64'(rd_d1), 64'h5A);
    check("stat21_rd_strobe", 64'(rd_rs1), 64'h02);
    check("stat21_hold_tx_d", 64'(rd_d2), 64'h5A);
    check("stat21_hold_tx_en", 64'(rd_en2), 64'h1);
    check("stat21_strobe_once", 64'(rd_rs2), 64'h0);

    wr(7'h20, 8'h77, s_hit, s_after, c_hit, c_end);
    check("wr20_no_ctrl", c_end, exp_ctrl);
    check("wr20_no_strobe", 64'(s_hit | s_after), 64'h0);
    rd(7'h7F, status_in);
    check("rd7f_tx_d", 64'(rd_d1), 64'h0);
    check("rd7f_tx_en", 64'(rd_en1), 64'h1);
    check("rd7f_no_strobe", 64'(rd_rs1), 64'h0);
    rd(7'h01, status_in);
    check("badcnt_two", 64'(rd_d1), 64'h02);

    for (int k = 0; k < 300; k++) rd(7'h7F, status_in);
    rd(7'h01, status_in);
    check("badcnt_saturate", 64'(rd_d1), 64'hFF);

    wr(7'h01, 8'h5B, s_hit, s_after, c_hit, c_end);
    rd(7'h01, status_in);
    check("badcnt_cleared", 64'(rd_d1), 64'h0);

    // Header only, frame closed before any data byte
    any_strobe = 1'b0;
    bus.reg_addr = 7'h13;
    bus.rw_out   = 1'b0;
    bus.addr_dv  = 1'b1;
    bus.rx_d     = 8'h66;
    tick();
    any_strobe |= |wr_strobe;
    tick();
    any_strobe |= |wr_strobe;
    bus.addr_dv = 1'b0;
    tick();
    any_strobe |= |wr_strobe;
    tick();
    any_strobe |= |wr_strobe;
    check("abort_no_ctrl", ctrl_regs, exp_ctrl);
    check("abort_no_strobe", 64'(any_strobe), 64'h0);
    rd(7'h01, status_in);
    check("abort_badcnt", 64'(rd_d1), 64'h0);
    wr(7'h13, 8'h99, s_hit, s_after, c_hit, c_end);
    exp_ctrl[31:24] = 8'h99;
    check("after_abort_ctrl", c_hit, exp_ctrl);
    check("after_abort_strobe", 64'(s_hit), 64'h08);
    rd(7'h13, status_in);
    check("after_abort_rd13", 64'(rd_d1), 64'h99);

    // Reset while holding read data
    bus.reg_addr = 7'h12;
    bus.rw_out   = 1'b1;
    bus.addr_dv  = 1'b1;
    tick();
    tick();
    check("pre_reset_tx_en", 64'(bus.tx_en), 64'h1);
    reset       = 1'b1;
    bus.addr_dv = 1'b0;
    tick();
    check("mid_reset_tx_en", 64'(bus.tx_en), 64'h0);
    check("mid_reset_tx_d", 64'(bus.tx_d), 64'h0);
    check("mid_reset_ctrl", ctrl_regs, 64'h0);
    reset = 1'b0;
    tick();
    rd(7'h00, status_in);
    check("post_reset_id", 64'(rd_d1), 64'hA5);
    rd(7'h12, status_in);
    check("post_reset_rd12", 64'(rd_d1), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
